// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width for N items; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; data_out always presents the oldest word.
module fifo_sync #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr    = write_en & ~full;
    assign do_rd    = read_en & ~empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    pick
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// granting bursts of up to MAX_BURST beats and rotating priority after each burst.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int IW        = idx_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   fifo_full,
    output logic                   fifo_write_en,
    output logic [WIDTH-1:0]       fifo_data_in,
    output logic [IW-1:0]          owner,
    output logic                   busy,
    output arb_state_t             state_dbg
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          beat;
    logic          last_beat;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .pick   (pick_idx)
    );

    assign owner_req = req[owner];
    assign beat      = (state == ARB_BURST) & owner_req & ~fifo_full;
    assign last_beat = beat & (beat_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // A full FIFO blocks the beat, so owner, count and state simply hold.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (beat) beat_cnt_nxt = beat_cnt + 1'b1;
                if (last_beat || !owner_req) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == ARB_BURST) gnt[owner] = owner_req & ~fifo_full;
    end

    assign fifo_write_en = |gnt;
    assign fifo_data_in  = req_data[owner*WIDTH +: WIDTH];
    assign busy          = (state == ARB_BURST);
    assign state_dbg     = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter feeding fifo_sync: queue-driven requesters, a
// transaction-level arbitration model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;
    localparam int SRC_D = 512;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             force_full;
    logic             fifo_full_in;
    logic             wr_en;
    logic [W-1:0]     wdata;
    logic [1:0]       owner;
    logic             busy;
    arb_state_t       state_dbg;
    logic             rd_en;
    logic [W-1:0]     rdata;
    logic             f_full;
    logic             f_empty;

    assign fifo_full_in = f_full | force_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .fifo_full     (fifo_full_in),
        .fifo_write_en (wr_en),
        .fifo_data_in  (wdata),
        .owner         (owner),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    fifo_sync #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
        .clk      (clk),
        .reset    (~reset_n),
        .write_en (wr_en),
        .data_in  (wdata),
        .read_en  (rd_en),
        .data_out (rdata),
        .full     (f_full),
        .empty    (f_empty)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] src_mem [N][SRC_D];
    int           src_len [N];
    int           src_pos [N];

    // Reference model: who owns the port, beats left in the grant, next priority.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_left;
    int m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_req();
        for (int i = 0; i < N; i++) begin
            req[i] = (src_pos[i] < src_len[i]);
            req_data[i*W +: W] = req[i] ? src_mem[i][src_pos[i]] : '0;
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (src_len[i] < SRC_D) begin
                src_mem[i][src_len[i]] = base + W'(k);
                src_len[i]++;
            end
        end
        update_req();
    endtask

    function automatic logic [N-1:0] expected_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_busy && req[m_owner] && !(m_count == DEPTH || force_full)) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic bit all_idle();
        bit r;
        r = 1'b1;
        for (int i = 0; i < N; i++) if (src_pos[i] != src_len[i]) r = 1'b0;
        return r && !m_busy && (m_count == 0);
    endfunction

    // One clock: check at the falling edge, advance models at the rising edge,
    // then let requesters present their next word.
    task automatic cycle();
        logic [N-1:0] eg;
        bit           rd;
        int           bo;
        int           idx;
        @(negedge clk);
        eg = expected_gnt();
        bo = m_owner;
        check("gnt", 32'(gnt), 32'(eg));
        check("write_en", 32'(wr_en), 32'(|eg));
        check("busy", 32'(busy), 32'(m_busy));
        check("owner", 32'(owner), m_owner);
        check("fifo_full", 32'(f_full), 32'(m_count == DEPTH));
        if (|eg) check("data_in", 32'(wdata), 32'(src_mem[bo][src_pos[bo]]));
        rd = rd_en && (m_count > 0);
        if (rd) check("fifo_data_out", 32'(rdata), 32'(exp_q[0]));
        @(posedge clk);
        if (rd) begin
            void'(exp_q.pop_front());
            m_count--;
        end
        if (|eg) begin
            exp_q.push_back(src_mem[bo][src_pos[bo]]);
            m_count++;
        end
        if (!m_busy) begin
            if (|req) begin
                idx = m_ptr;
                while (!req[idx]) idx = (idx + 1) % N;
                m_owner = idx;
                m_left  = MB;
                m_busy  = 1'b1;
            end
        end else begin
            if (|eg) m_left--;
            if (((|eg) && m_left == 0) || !req[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        #1;
        if (|eg) src_pos[bo]++;
        update_req();
    endtask

    // Reset between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_write_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_state", 32'(state_dbg), 32'(ARB_IDLE));
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_left = 0; m_count = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_pos[i] = src_len[i];
        update_req();
        force_full = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rd_en = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (all_idle()) done = 1'b1;
            else cycle();
        end
        check("drain_done", 32'(done), 1);
        rd_en = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        force_full = 1'b0;
        rd_en      = 1'b0;
        req        = '0;
        req_data   = '0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_left = 0; m_count = 0;
        #12;
        check("init_busy", 32'(busy), 0);
        check("init_owner", 32'(owner), 0);
        check("init_empty", 32'(f_empty), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Abandon a burst of owner 0 with a mid-cycle reset.
        for (int i = 0; i < N; i++) load(i, 8'hE0 + W'(i), 4);
        repeat (3) cycle();
        check("pre_rst_busy", 32'(busy), 1);
        async_reset();

        // Fairness: owners 0,1,2,3 in order, four beats each.
        for (int i = 0; i < N; i++) load(i, W'(i * 16), 4);
        repeat (25) cycle();
        drain();

        // Single requester: two bursts of four.
        load(1, 8'h10, 8);
        drain();

        // Full stall after two beats of owner 2.
        load(2, 8'h20, 4);
        for (int c = 0; c < 20 && src_pos[2] < src_len[2] - 2; c++) cycle();
        force_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("stall_owner", 32'(owner), 2);
            check("stall_busy", 32'(busy), 1);
            check("stall_gnt", 32'(gnt), 0);
        end
        force_full = 1'b0;
        drain();

        // Early release: requester 0 stops after two beats, requester 3 follows.
        async_reset();
        load(0, 8'h40, 2);
        load(3, 8'h70, 4);
        repeat (5) cycle();
        #3;
        check("early_owner", 32'(owner), 3);
        check("early_gnt", 32'(gnt), 32'(4'b1000));
        drain();

        // Randomized traffic with random backpressure and reads.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_len[i] - src_pos[i] < 3 && $urandom_range(0, 3) == 0)
                    load(i, W'($urandom), $urandom_range(1, 5));
            end
            force_full = ($urandom_range(0, 9) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            cycle();
        end
        force_full = 1'b0;
        drain();

        // Backpressure end-to-end: fill the FIFO with no reads.
        async_reset();
        load(0, 8'h80, 8);
        load(1, 8'h90, 8);
        load(2, 8'hA0, 8);
        repeat (40) cycle();
        check("bp_full", 32'(f_full), 1);
        check("bp_gnt", 32'(gnt), 0);
        check("bp_count", m_count, DEPTH);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
